// File: rtl/mc_controller.sv
// mc_controller: multi-cycle RV32I control unit.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. It traps on
// illegal encodings, misaligned loads/stores, and memory waits that reach TIMEOUT.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   instr                 instruction register contents
//   rs1_val, rs2_val      register read data for branch compare
//   addr_lo               ALU result bits [1:0] for alignment check
//   mem_ready             memory access completes this cycle
//   mem_req/mem_we/addr_sel/mem_size/mem_unsigned   memory control
//   ir_we/pc_we/reg_write strobes; pc_src/result_src datapath muxes
//   alu_src_a/alu_src_b/alu_control/imm_src        ALU and immediate control
//   fault/fault_cause     sticky trap indication; state = FSM encoding
module mc_controller #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [1:0]      addr_lo,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic            addr_sel,
    output logic [1:0]      mem_size,
    output logic            mem_unsigned,
    output logic            ir_we,
    output logic            pc_we,
    output logic            reg_write,
    output logic [1:0]      pc_src,
    output logic [1:0]      result_src,
    output logic [1:0]      alu_src_a,
    output logic            alu_src_b,
    output logic [3:0]      alu_control,
    output logic [2:0]      imm_src,
    output logic            fault,
    output logic [1:0]      fault_cause,
    output logic [2:0]      state
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t        cur;
    logic [CW-1:0] wait_cnt;
    logic          fault_q;
    logic [1:0]    cause_q;

    // Instruction field decode
    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7b5;
    logic       is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic       is_load, is_store, is_opimm, is_op;
    logic       illegal, misaligned, taken, wait_expired;
    logic       unused_bits;

    assign opcode    = instr[6:0];
    assign f3        = instr[14:12];
    assign f7b5      = instr[30];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign is_lui    = (opcode == 7'b0110111);
    assign is_auipc  = (opcode == 7'b0010111);
    assign is_jal    = (opcode == 7'b1101111);
    assign is_jalr   = (opcode == 7'b1100111);
    assign is_branch = (opcode == 7'b1100011);
    assign is_load   = (opcode == 7'b0000011);
    assign is_store  = (opcode == 7'b0100011);
    assign is_opimm  = (opcode == 7'b0010011);
    assign is_op     = (opcode == 7'b0110011);

    assign illegal = !(is_lui | is_auipc | is_jal | is_jalr | is_branch |
                       is_load | is_store | is_opimm | is_op)
                   | (is_branch & (f3 == 3'b010 || f3 == 3'b011))
                   | (is_load & (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
                   | (is_store & (f3 > 3'b010));

    assign misaligned = ((f3[1:0] == 2'b01) & addr_lo[0])
                      | ((f3[1:0] == 2'b10) & (addr_lo != 2'b00));

    assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));

    // Branch condition evaluation
    always_comb begin
        taken = 1'b0;
        case (f3)
            3'b000:  taken = (rs1_val == rs2_val);
            3'b001:  taken = (rs1_val != rs2_val);
            3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  taken = (rs1_val <  rs2_val);
            3'b111:  taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

    // State, wait counter and sticky fault registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
            cause_q  <= 2'b00;
        end else begin
            case (cur)
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        if (cur == S_FETCH)  cur <= S_DECODE;
                        else if (is_load)    cur <= S_WB;
                        else                 cur <= S_FETCH;
                    end else if (wait_expired) begin
                        cur     <= S_TRAP;
                        fault_q <= 1'b1;
                        cause_q <= 2'b10;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_DECODE: begin
                    if (illegal) begin
                        cur     <= S_TRAP;
                        fault_q <= 1'b1;
                        cause_q <= 2'b01;
                    end else begin
                        cur <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_branch | is_jal | is_jalr) begin
                        cur      <= S_FETCH;
                        wait_cnt <= '0;
                    end else if (is_load | is_store) begin
                        if (misaligned) begin
                            cur     <= S_TRAP;
                            fault_q <= 1'b1;
                            cause_q <= 2'b11;
                        end else begin
                            cur      <= S_MEM;
                            wait_cnt <= '0;
                        end
                    end else begin
                        cur <= S_WB;
                    end
                end
                S_WB: begin
                    cur      <= S_FETCH;
                    wait_cnt <= '0;
                end
                S_TRAP:  cur <= S_TRAP;
                default: cur <= S_FETCH;
            endcase
        end
    end

    // Output decode from current state and inputs
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        addr_sel     = 1'b0;
        mem_size     = 2'b00;
        mem_unsigned = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        reg_write    = 1'b0;
        pc_src       = 2'b00;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 1'b0;
        alu_control  = 4'b0000;
        imm_src      = 3'b000;

        if (is_store)                imm_src = 3'b001;
        else if (is_branch)          imm_src = 3'b010;
        else if (is_lui | is_auipc)  imm_src = 3'b011;
        else if (is_jal)             imm_src = 3'b100;

        // ALU controls are meaningful only while the datapath computes
        if (cur == S_EXEC || cur == S_MEM || cur == S_WB) begin
            if (is_auipc)     alu_src_a = 2'b01;
            else if (is_lui)  alu_src_a = 2'b10;
            alu_src_b = !(is_op | is_branch);
            if (is_op)        alu_control = {f7b5, f3};
            else if (is_opimm) alu_control = {(f3 == 3'b101) & f7b5, f3};
        end

        case (cur)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_size = 2'b10;
                ir_we    = mem_ready;
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_we  = 1'b1;
                    pc_src = taken ? 2'b01 : 2'b00;
                end else if (is_jal | is_jalr) begin
                    reg_write  = 1'b1;
                    result_src = 2'b10;
                    pc_we      = 1'b1;
                    pc_src     = is_jal ? 2'b01 : 2'b10;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                addr_sel     = 1'b1;
                mem_we       = is_store;
                mem_size     = f3[1:0];
                mem_unsigned = f3[2];
                pc_we        = is_store & mem_ready;
            end
            S_WB: begin
                reg_write  = 1'b1;
                result_src = is_load ? 2'b01 : 2'b00;
                pc_we      = 1'b1;
            end
            default: ;
        endcase

        // No strobe may fire in a cycle where reset is being applied
        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign state       = cur;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller (TIMEOUT reduced to 4).
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] rs1_val, rs2_val;
    logic [1:0]  addr_lo;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_sel, mem_unsigned;
    logic [1:0]  mem_size;
    logic        ir_we, pc_we, reg_write;
    logic [1:0]  pc_src, result_src, alu_src_a;
    logic        alu_src_b;
    logic [3:0]  alu_control;
    logic [2:0]  imm_src;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    mc_controller #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .instr(instr),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .addr_lo(addr_lo),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .ir_we(ir_we), .pc_we(pc_we), .reg_write(reg_write),
        .pc_src(pc_src), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
        .fault(fault), .fault_cause(fault_cause), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    // From FETCH: present instruction, complete fetch, pass DECODE; ends in EXEC
    task automatic fetch_decode(input logic [31:0] ins, input logic [2:0] exp_imm);
        instr = ins;
        mem_ready = 1'b1;
        #1;
        check("fetch_state", 32'(state), 32'd0);
        check("fetch_ir_we", 32'(ir_we), 32'd1);
        tick();
        mem_ready = 1'b1;   // must be ignored in DECODE
        #1;
        check("decode_state", 32'(state), 32'd1);
        check("decode_ir_we", 32'(ir_we), 32'd0);
        check("decode_imm_src", 32'(imm_src), 32'(exp_imm));
        mem_ready = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  exp_src;
    } br_vec_t;

    br_vec_t br_tab [4];

    initial begin
        br_tab[0] = '{3'b100, 32'hFFFF_FFFF, 32'd1, 2'b01};  // BLT  -1 < 1
        br_tab[1] = '{3'b110, 32'hFFFF_FFFF, 32'd1, 2'b00};  // BLTU big < 1 false
        br_tab[2] = '{3'b000, 32'd5,         32'd5, 2'b01};  // BEQ
        br_tab[3] = '{3'b101, 32'hFFFF_FFFF, 32'd1, 2'b00};  // BGE  -1 >= 1 false

        reset = 1'b1; instr = 32'h0; rs1_val = '0; rs2_val = '0;
        addr_lo = 2'b00; mem_ready = 1'b0;

        // Reset behaviour
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_cause", 32'(fault_cause), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_mem_req", 32'(mem_req), 32'd1);
        check("post_rst_addr_sel", 32'(addr_sel), 32'd0);
        check("post_rst_mem_size", 32'(mem_size), 32'd2);

        // ADDI x1,x0,5: 0,1,2,4,0
        fetch_decode(32'h0050_0093, 3'b000);
        #1;
        check("addi_exec_state", 32'(state), 32'd2);
        check("addi_exec_srcb", 32'(alu_src_b), 32'd1);
        check("addi_exec_pc_we", 32'(pc_we), 32'd0);
        tick();
        check("addi_wb_state", 32'(state), 32'd4);
        check("addi_wb_reg_write", 32'(reg_write), 32'd1);
        check("addi_wb_pc_we", 32'(pc_we), 32'd1);
        check("addi_wb_alu_ctl", 32'(alu_control), 32'd0);
        check("addi_wb_result_src", 32'(result_src), 32'd0);
        tick();
        check("addi_back_fetch", 32'(state), 32'd0);
        check("addi_fetch_reg_write", 32'(reg_write), 32'd0);

        // SUB x3,x1,x2 (OP, funct7[5]=1): alu_control = 1000, src_b = 0
        fetch_decode(32'h4020_81B3, 3'b000);
        #1;
        check("sub_alu_ctl", 32'(alu_control), 32'h8);
        check("sub_srcb", 32'(alu_src_b), 32'd0);
        tick();
        tick();

        // LUI x1,0x12345: alu_src_a = 10
        fetch_decode(32'h1234_50B7, 3'b011);
        #1;
        check("lui_src_a", 32'(alu_src_a), 32'd2);
        tick();
        tick();

        // Branches
        for (int i = 0; i < 4; i++) begin
            fetch_decode(32'h0020_8063 | (32'(br_tab[i].f3) << 12), 3'b010);
            rs1_val = br_tab[i].a;
            rs2_val = br_tab[i].b;
            #1;
            check("br_pc_we", 32'(pc_we), 32'd1);
            check("br_pc_src", 32'(pc_src), 32'(br_tab[i].exp_src));
            tick();
            check("br_back_fetch", 32'(state), 32'd0);
        end

        // JAL and JALR
        fetch_decode(32'h0000_00EF, 3'b100);
        #1;
        check("jal_reg_write", 32'(reg_write), 32'd1);
        check("jal_result_src", 32'(result_src), 32'd2);
        check("jal_pc_src", 32'(pc_src), 32'd1);
        tick();
        fetch_decode(32'h0000_80E7, 3'b000);
        #1;
        check("jalr_pc_src", 32'(pc_src), 32'd2);
        tick();
        check("jalr_back_fetch", 32'(state), 32'd0);

        // LW aligned, mem_ready on third MEM cycle
        fetch_decode(32'h0001_2083, 3'b000);
        addr_lo = 2'b00;
        #1;
        check("lw_exec_srcb", 32'(alu_src_b), 32'd1);
        check("lw_exec_alu_ctl", 32'(alu_control), 32'd0);
        tick();
        check("lw_mem1_state", 32'(state), 32'd3);
        check("lw_mem_req", 32'(mem_req), 32'd1);
        check("lw_addr_sel", 32'(addr_sel), 32'd1);
        check("lw_mem_we", 32'(mem_we), 32'd0);
        check("lw_mem_size", 32'(mem_size), 32'd2);
        tick();
        check("lw_mem2_state", 32'(state), 32'd3);
        tick();
        mem_ready = 1'b1;
        #1;
        check("lw_mem3_state", 32'(state), 32'd3);
        check("lw_mem3_pc_we", 32'(pc_we), 32'd0);
        tick();
        mem_ready = 1'b0;
        #1;
        check("lw_wb_state", 32'(state), 32'd4);
        check("lw_wb_result_src", 32'(result_src), 32'd1);
        check("lw_wb_reg_write", 32'(reg_write), 32'd1);
        tick();
        check("lw_back_fetch", 32'(state), 32'd0);

        // SW completing immediately in MEM
        fetch_decode(32'h0020_A023, 3'b001);
        addr_lo = 2'b00;
        #1;
        tick();
        mem_ready = 1'b1;
        #1;
        check("sw_mem_we", 32'(mem_we), 32'd1);
        check("sw_pc_we", 32'(pc_we), 32'd1);
        check("sw_pc_src", 32'(pc_src), 32'd0);
        tick();
        mem_ready = 1'b0;
        #1;
        check("sw_back_fetch", 32'(state), 32'd0);

        // Misaligned LW -> TRAP cause 11
        fetch_decode(32'h0001_2083, 3'b000);
        addr_lo = 2'b10;
        #1;
        tick();
        check("lw_mis_state", 32'(state), 32'd5);
        check("lw_mis_fault", 32'(fault), 32'd1);
        check("lw_mis_cause", 32'(fault_cause), 32'd3);
        check("trap_mem_req", 32'(mem_req), 32'd0);
        addr_lo = 2'b00;
        do_reset();
        check("mis_rst_fault", 32'(fault), 32'd0);

        // Fetch timeout with TIMEOUT=4
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("to_still_fetch", 32'(state), 32'd0);
        tick();
        check("to_state", 32'(state), 32'd5);
        check("to_cause", 32'(fault_cause), 32'd2);
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("to_fault_held", 32'(fault), 32'd1);
        check("to_state_held", 32'(state), 32'd5);
        check("to_ir_we", 32'(ir_we), 32'd0);
        do_reset();

        // Illegal instruction
        fetch_decode(32'hFFFF_FFFF, 3'b000);
        #1;
        check("ill_state", 32'(state), 32'd5);
        check("ill_cause", 32'(fault_cause), 32'd1);
        do_reset();

        // Reset in the middle of a store's MEM phase
        fetch_decode(32'h0020_A023, 3'b001);
        #1;
        tick();
        check("swr_mem_state", 32'(state), 32'd3);
        check("swr_mem_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        check("swr_rst_mem_we", 32'(mem_we), 32'd0);
        check("swr_rst_mem_req", 32'(mem_req), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("swr_after_state", 32'(state), 32'd0);
        check("swr_after_mem_we", 32'(mem_we), 32'd0);
        check("swr_after_mem_req", 32'(mem_req), 32'd1);
        check("swr_after_addr_sel", 32'(addr_sel), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
